// File: rtl/vga_tile_renderer_if.sv
// vga_tile_renderer_if: tile-map fetch bus and VGA pin bundle
interface vga_tile_renderer_if #(parameter int ADDR_W = 9);
  logic [ADDR_W-1:0] o_tile_addr;
  logic [3:0] i_tile_data;
  logic o_VGA_HSync;
  logic o_VGA_VSync;
  logic [2:0] o_VGA_Red;
  logic [2:0] o_VGA_Grn;
  logic [2:0] o_VGA_Blu;
  logic o_frame_start;
  logic o_collision;
  modport master(
    output o_tile_addr, o_VGA_HSync, o_VGA_VSync, o_VGA_Red, o_VGA_Grn, o_VGA_Blu, o_frame_start, o_collision,
    input i_tile_data
  );
  modport slave(
    input o_tile_addr, o_VGA_HSync, o_VGA_VSync, o_VGA_Red, o_VGA_Grn, o_VGA_Blu, o_frame_start, o_collision,
    output i_tile_data
  );
endinterface

// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer: 640x480 tile-map renderer with sprite/player overlay and per-frame collision pulse
module vga_tile_renderer #(
  parameter int H_SYNC_CYCLES = 92,
  parameter int H_BACK_PORCH = 50,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT_PORCH = 18,
  parameter int V_SYNC_CYCLES = 2,
  parameter int V_BACK_PORCH = 33,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int TILE_LOG2 = 5,
  parameter int GRID_W = 20,
  parameter int GRID_H = 15,
  parameter int CX_W = 5,
  parameter int CY_W = 4,
  parameter int ADDR_W = 9,
  parameter int N_SPRITES = 10,
  parameter logic [8:0] PAL_T1 = 9'o051,
  parameter logic [8:0] PAL_T2 = 9'o111,
  parameter logic [8:0] PAL_SPR = 9'o700,
  parameter logic [8:0] PAL_PLY = 9'o007
) (
  input logic i_Clk,
  input logic i_reset,
  input logic [N_SPRITES*CX_W-1:0] i_sprite_x,
  input logic [N_SPRITES*CY_W-1:0] i_sprite_y,
  input logic [N_SPRITES-1:0] i_sprite_len2,
  input logic [N_SPRITES-1:0] i_sprite_en,
  input logic [CX_W-1:0] i_player_x,
  input logic [CY_W-1:0] i_player_y,
  vga_tile_renderer_if.master bus
);
  localparam int H_LINE = H_SYNC_CYCLES + H_BACK_PORCH + H_DISPLAY + H_FRONT_PORCH;
  localparam int V_FRAME = V_SYNC_CYCLES + V_BACK_PORCH + V_DISPLAY + V_FRONT_PORCH;
  localparam int HW = $clog2(H_LINE);
  localparam int VW = $clog2(V_FRAME);
  localparam int CXF = HW - TILE_LOG2;
  localparam int CYF = VW - TILE_LOG2;
  localparam logic [HW-1:0] H_LAST = HW'(H_LINE - 1);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC_CYCLES);
  localparam logic [HW-1:0] H_ACT0 = HW'(H_SYNC_CYCLES + H_BACK_PORCH);
  localparam logic [HW-1:0] H_ACT1 = HW'(H_SYNC_CYCLES + H_BACK_PORCH + H_DISPLAY);
  localparam logic [VW-1:0] V_LAST = VW'(V_FRAME - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC_CYCLES);
  localparam logic [VW-1:0] V_ACT0 = VW'(V_SYNC_CYCLES + V_BACK_PORCH);
  localparam logic [VW-1:0] V_ACT1 = VW'(V_SYNC_CYCLES + V_BACK_PORCH + V_DISPLAY);
  localparam logic [VW-1:0] V_PRE_BLANK = VW'(V_SYNC_CYCLES + V_BACK_PORCH + V_DISPLAY - 1);
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic h_wrap, v_last, draw0, hs0, vs0;
  logic [CXF-1:0] cx0;
  logic [CYF-1:0] cy0;
  logic [ADDR_W-1:0] addr0;
  logic draw1, hs1, vs1, spr_hit1, ply_hit1;
  logic [CX_W-1:0] cx1;
  logic [CY_W-1:0] cy1;
  logic draw2, hs2, vs2, spr2, ply2;
  logic [8:0] pix;
  logic flag, col_evt;
  // stage 0: decode the raw counters into cell coordinates, map address and sync levels
  always_comb begin
    h_wrap = h == H_LAST;
    v_last = v == V_LAST;
    cx0 = CXF'((h - H_ACT0) >> TILE_LOG2);
    cy0 = CYF'((v - V_ACT0) >> TILE_LOG2);
    draw0 = h >= H_ACT0 && h < H_ACT1 && v >= V_ACT0 && v < V_ACT1 && cx0 < CXF'(GRID_W) && cy0 < CYF'(GRID_H);
    addr0 = ADDR_W'(cy0) * ADDR_W'(GRID_W) + ADDR_W'(cx0);
    hs0 = h < H_SYNC_END;
    vs0 = v < V_SYNC_END;
    col_evt = h_wrap && v == V_PRE_BLANK && flag;
  end
  // raster counters; frame_start is registered so it is high while the counters read (0,0)
  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      h <= '0;
      v <= '0;
      bus.o_frame_start <= 1'b0;
    end else begin
      h <= h_wrap ? '0 : h + HW'(1);
      v <= h_wrap ? (v_last ? '0 : v + VW'(1)) : v;
      bus.o_frame_start <= h_wrap && v_last;
    end
  end
  // stage 1 register: issue the map read and carry pixel context alongside it
  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      bus.o_tile_addr <= '0;
      draw1 <= 1'b0;
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      cx1 <= '0;
      cy1 <= '0;
    end else begin
      if (draw0) bus.o_tile_addr <= addr0;
      draw1 <= draw0;
      hs1 <= hs0;
      vs1 <= vs0;
      cx1 <= cx0[CX_W-1:0];
      cy1 <= cy0[CY_W-1:0];
    end
  end
  // stage 1 hit test; x+1 is widened so a sprite at the last column never wraps to column 0
  always_comb begin
    spr_hit1 = 1'b0;
    for (int k = 0; k < N_SPRITES; k++)
      spr_hit1 = spr_hit1 | (i_sprite_en[k] && cy1 == i_sprite_y[k*CY_W +: CY_W] &&
        (cx1 == i_sprite_x[k*CX_W +: CX_W] ||
         (i_sprite_len2[k] && {1'b0, cx1} == {1'b0, i_sprite_x[k*CX_W +: CX_W]} + (CX_W+1)'(1))));
    ply_hit1 = cx1 == i_player_x && cy1 == i_player_y;
  end
  // stage 2 register: hits wait here for the tile code arriving from the map
  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      draw2 <= 1'b0;
      hs2 <= 1'b0;
      vs2 <= 1'b0;
      spr2 <= 1'b0;
      ply2 <= 1'b0;
    end else begin
      draw2 <= draw1;
      hs2 <= hs1;
      vs2 <= vs1;
      spr2 <= spr_hit1;
      ply2 <= ply_hit1;
    end
  end
  // colour priority: blank, sprite, player, then tile palette
  always_comb begin
    pix = !draw2 ? '0 : spr2 ? PAL_SPR : ply2 ? PAL_PLY :
      bus.i_tile_data == 4'd1 ? PAL_T1 : bus.i_tile_data == 4'd2 ? PAL_T2 : '0;
  end
  // output register: colour and syncs leave together so each pixel lines up with its own sync
  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      bus.o_VGA_Red <= '0;
      bus.o_VGA_Grn <= '0;
      bus.o_VGA_Blu <= '0;
      bus.o_VGA_HSync <= 1'b1;
      bus.o_VGA_VSync <= 1'b1;
    end else begin
      bus.o_VGA_Red <= pix[8:6];
      bus.o_VGA_Grn <= pix[5:3];
      bus.o_VGA_Blu <= pix[2:0];
      bus.o_VGA_HSync <= ~hs2;
      bus.o_VGA_VSync <= ~vs2;
    end
  end
  // sticky overlap flag, reported once as vblank begins and then cleared
  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      flag <= 1'b0;
      bus.o_collision <= 1'b0;
    end else begin
      bus.o_collision <= col_evt;
      flag <= col_evt ? 1'b0 : flag | (draw1 && spr_hit1 && ply_hit1);
    end
  end
endmodule

// File: tb/tb_vga_tile_renderer.sv
// tb_vga_tile_renderer: full-size and shrunken-timing renderers checked against a pixel-level model
module tb_vga_tile_renderer;
  localparam int N_CYC = 56000;
  localparam int HS[2] = '{92, 4};
  localparam int HBP[2] = '{50, 3};
  localparam int HD[2] = '{640, 42};
  localparam int HF[2] = '{18, 3};
  localparam int VS[2] = '{2, 2};
  localparam int VBP[2] = '{33, 3};
  localparam int VD[2] = '{480, 31};
  localparam int VF[2] = '{10, 2};
  localparam int TL[2] = '{5, 1};
  logic clk = 1'b0;
  logic rst_b, rst_s;
  logic [49:0] sx [2];
  logic [39:0] sy [2];
  logic [9:0] len [2];
  logic [9:0] en [2];
  logic [4:0] px [2];
  logic [3:0] py [2];
  logic [3:0] mem [2][512];
  int c [2];
  int n_chk = 0, n_fail = 0, frame_s = 0;
  bit coll_exp = 0, did_rst = 0;
  always #5 clk = ~clk;
  vga_tile_renderer_if bus_b();
  vga_tile_renderer_if bus_s();
  vga_tile_renderer dut (
    .i_Clk(clk), .i_reset(rst_b), .i_sprite_x(sx[0]), .i_sprite_y(sy[0]), .i_sprite_len2(len[0]),
    .i_sprite_en(en[0]), .i_player_x(px[0]), .i_player_y(py[0]), .bus(bus_b)
  );
  vga_tile_renderer #(
    .H_SYNC_CYCLES(4), .H_BACK_PORCH(3), .H_DISPLAY(42), .H_FRONT_PORCH(3),
    .V_SYNC_CYCLES(2), .V_BACK_PORCH(3), .V_DISPLAY(31), .V_FRONT_PORCH(2), .TILE_LOG2(1)
  ) dut_s (
    .i_Clk(clk), .i_reset(rst_s), .i_sprite_x(sx[1]), .i_sprite_y(sy[1]), .i_sprite_len2(len[1]),
    .i_sprite_en(en[1]), .i_player_x(px[1]), .i_player_y(py[1]), .bus(bus_s)
  );
  // map memories answer one clock after the address
  always @(posedge clk) begin
    bus_b.i_tile_data <= mem[0][bus_b.o_tile_addr];
    bus_s.i_tile_data <= mem[1][bus_s.o_tile_addr];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  function automatic bit covers(int id, int cx, int cy);
    for (int k = 0; k < 10; k++)
      if (en[id][k] && cy == int'(sy[id][k*4 +: 4]) &&
          (cx == int'(sx[id][k*5 +: 5]) || (len[id][k] && cx == int'(sx[id][k*5 +: 5]) + 1)))
        return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic [8:0] ref_pix(int id, int h, int v);
    int x, y, cx, cy;
    x = h - HS[id] - HBP[id];
    y = v - VS[id] - VBP[id];
    if (x < 0 || x >= HD[id] || y < 0 || y >= VD[id]) return 9'o000;
    cx = x / (1 << TL[id]);
    cy = y / (1 << TL[id]);
    if (cx >= 20 || cy >= 15) return 9'o000;
    if (covers(id, cx, cy)) return 9'o700;
    if (cx == int'(px[id]) && cy == int'(py[id])) return 9'o007;
    case (mem[id][cy*20 + cx])
      4'd1: return 9'o051;
      4'd2: return 9'o111;
      default: return 9'o000;
    endcase
  endfunction
  task automatic check_dut(input int id, input logic [8:0] rgb, input logic hsy, input logic vsy,
                           input logic fs, input logic col);
    int hl, vf, h, v, hp, vp;
    logic [8:0] er;
    logic eh, ev;
    string s;
    s = id ? "_s" : "_b";
    hl = HS[id] + HBP[id] + HD[id] + HF[id];
    vf = VS[id] + VBP[id] + VD[id] + VF[id];
    h = c[id] % hl;
    v = (c[id] / hl) % vf;
    er = 9'o000;
    eh = 1'b1;
    ev = 1'b1;
    if (c[id] >= 3) begin
      hp = (c[id] - 3) % hl;
      vp = ((c[id] - 3) / hl) % vf;
      er = ref_pix(id, hp, vp);
      eh = hp >= HS[id];
      ev = vp >= VS[id];
    end
    check({"rgb", s}, 32'(rgb), 32'(er));
    check({"hsync", s}, 32'(hsy), 32'(eh));
    check({"vsync", s}, 32'(vsy), 32'(ev));
    check({"frame_start", s}, 32'(fs), 32'(c[id] > 0 && h == 0 && v == 0));
    check({"collision", s}, 32'(col), 32'(h == 0 && v == VS[id] + VBP[id] + VD[id] && (id == 1 && coll_exp)));
  endtask
  task automatic new_frame();
    int j;
    if (frame_s < 3) begin
      sx[1] = '0;
      sy[1] = '0;
      sx[1][15 +: 5] = 5'd19;
      sy[1][12 +: 4] = 4'd2;
      len[1] = 10'b0000001000;
      en[1] = frame_s == 2 ? 10'd0 : 10'b0000001000;
      px[1] = frame_s == 1 ? 5'd5 : 5'd19;
      py[1] = 4'd2;
    end else begin
      for (int k = 0; k < 10; k++) begin
        sx[1][k*5 +: 5] = 5'($urandom_range(0, 21));
        sy[1][k*4 +: 4] = 4'($urandom_range(0, 15));
      end
      en[1] = 10'($urandom);
      len[1] = 10'($urandom);
      j = $urandom_range(0, 9);
      px[1] = sx[1][j*5 +: 5] + 5'($urandom_range(0, 1));
      py[1] = sy[1][j*4 +: 4];
      if ($urandom_range(0, 3) == 0) begin
        px[1] = 5'($urandom_range(0, 31));
        py[1] = 4'($urandom_range(0, 15));
      end
    end
    coll_exp = px[1] < 5'd20 && py[1] < 4'd15 && covers(1, int'(px[1]), int'(py[1]));
    frame_s++;
  endtask
  initial begin
    int hl1, vf1;
    hl1 = HS[1] + HBP[1] + HD[1] + HF[1];
    vf1 = VS[1] + VBP[1] + VD[1] + VF[1];
    rst_b = 1'b1;
    rst_s = 1'b1;
    for (int a = 0; a < 512; a++) begin
      mem[0][a] = a < 20 ? 4'd1 : a < 300 ? 4'd2 : 4'd0;
      mem[1][a] = 4'($urandom_range(0, 3));
    end
    for (int k = 0; k < 10; k++) begin
      sx[0][k*5 +: 5] = 5'($urandom_range(0, 21));
      sy[0][k*4 +: 4] = 4'($urandom_range(0, 1));
    end
    en[0] = 10'($urandom);
    len[0] = 10'($urandom);
    sx[0][15 +: 5] = 5'd19;
    sy[0][12 +: 4] = 4'd1;
    en[0][3] = 1'b1;
    len[0][3] = 1'b1;
    px[0] = 5'($urandom_range(0, 19));
    py[0] = 4'($urandom_range(0, 1));
    sx[1] = '0;
    sy[1] = '0;
    en[1] = '0;
    len[1] = '0;
    px[1] = '0;
    py[1] = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_rgb", 32'({bus_b.o_VGA_Red, bus_b.o_VGA_Grn, bus_b.o_VGA_Blu}), 32'd0);
    check("rst_sync", 32'({bus_b.o_VGA_HSync, bus_b.o_VGA_VSync}), 32'd3);
    check("rst_addr", 32'(bus_b.o_tile_addr), 32'd0);
    check("rst_pulses", 32'({bus_b.o_frame_start, bus_b.o_collision, bus_s.o_frame_start, bus_s.o_collision}), 32'd0);
    rst_b = 1'b0;
    rst_s = 1'b0;
    c[0] = 0;
    c[1] = 0;
    for (int i = 0; i < N_CYC; i++) begin
      check_dut(0, {bus_b.o_VGA_Red, bus_b.o_VGA_Grn, bus_b.o_VGA_Blu}, bus_b.o_VGA_HSync,
                bus_b.o_VGA_VSync, bus_b.o_frame_start, bus_b.o_collision);
      check_dut(1, {bus_s.o_VGA_Red, bus_s.o_VGA_Grn, bus_s.o_VGA_Blu}, bus_s.o_VGA_HSync,
                bus_s.o_VGA_VSync, bus_s.o_frame_start, bus_s.o_collision);
      if (c[1] % (hl1 * vf1) == 0) new_frame();
      if (!did_rst && frame_s == 6 && c[1] % hl1 == 30 && (c[1] / hl1) % vf1 == 20) begin
        rst_s = 1'b1;
        did_rst = 1'b1;
      end
      c[0]++;
      c[1]++;
      @(negedge clk);
      if (rst_s) begin
        rst_s = 1'b0;
        c[1] = 0;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
